// File: rtl/enc_pwm_pkg.sv
// rtl/enc_pwm_pkg.sv - shared constants and helpers for the encoder-to-PWM mixer
//
// Contents:
//   DIR_UP / DIR_DOWN  debounced B level at an A rise that selects the step direction
//   ch_w()             channel-select width for a channel count (never below 1)
//   phase_off()        PWM phase offset of a channel when phases are staggered

package enc_pwm_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

    // Channels are spread evenly over one PWM period.
    function automatic int phase_off(input int ch, input int num_ch, input int width);
        return ch * ((1 << width) / num_ch);
    endfunction

endpackage

// File: rtl/enc_channel.sv
// rtl/enc_channel.sv - one encoder channel: synchroniser, debouncer, quadrature decode, level register
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   enc_a     in   encoder A pin, asynchronous
//   enc_b     in   encoder B pin, asynchronous
//   strobe    in   debounce sample enable
//   sat_mode  in   1 = clamp level at 0 / max, 0 = wrap
//   load      in   direct level write for this channel
//   load_val  in   value written on load
//   level     out  current level

module enc_channel
    import enc_pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             strobe,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] level
);

    localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] LEVEL_MAX = '1;

    logic             a_s1, a_s2, b_s1, b_s2;
    logic             a_prev, b_prev;
    logic             a_db, b_db, a_db_d;
    logic             rise;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] level_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1   <= 1'b0;
            a_s2   <= 1'b0;
            b_s1   <= 1'b0;
            b_s2   <= 1'b0;
            a_prev <= 1'b0;
            b_prev <= 1'b0;
            a_db   <= 1'b0;
            b_db   <= 1'b0;
            a_db_d <= 1'b0;
            level  <= '0;
        end else begin
            a_s1 <= enc_a;
            a_s2 <= a_s1;
            b_s1 <= enc_b;
            b_s2 <= b_s1;
            // A new value must be seen on two consecutive strobes before it is accepted.
            if (strobe) begin
                a_prev <= a_s2;
                b_prev <= b_s2;
                if (a_s2 == a_prev) a_db <= a_s2;
                if (b_s2 == b_prev) b_db <= b_s2;
            end
            a_db_d <= a_db;
            // A direct load wins; an encoder step in the same cycle is discarded.
            if (load) begin
                level <= load_val;
            end else if (rise) begin
                level <= level_next;
            end
        end
    end

    assign rise = a_db & ~a_db_d;

    // One extra bit exposes carry on the way up and borrow on the way down.
    always_comb begin
        sum        = {1'b0, level} + STEP_X;
        diff       = {1'b0, level} - STEP_X;
        level_next = level;
        if (b_db == DIR_UP) begin
            level_next = (sat_mode && sum[WIDTH]) ? LEVEL_MAX : sum[WIDTH-1:0];
        end else if (b_db == DIR_DOWN) begin
            level_next = (sat_mode && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/enc_pwm_mixer.sv
// rtl/enc_pwm_mixer.sv - NUM_CH rotary encoders driving phase-spread, glitch-free PWM outputs
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   enc_a     in   [NUM_CH] encoder A pins, asynchronous
//   enc_b     in   [NUM_CH] encoder B pins, asynchronous
//   sat_mode  in   1 = saturate levels, 0 = wrap
//   load_en   in   direct level write strobe
//   load_ch   in   [CH_W] channel to write (out-of-range ignored)
//   load_val  in   [WIDTH] value to write
//   rd_sel    in   [CH_W] readback channel select
//   rd_data   out  [WIDTH] registered level[rd_sel], 0 when out of range
//   pwm_out   out  [NUM_CH] registered PWM outputs

module enc_pwm_mixer
    import enc_pwm_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int WIDTH        = 8,
    parameter  int STEP         = 1,
    parameter  int DB_DIV       = 1,
    parameter  int PHASE_SPREAD = 1,
    localparam int CH_W         = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enc_a,
    input  logic [NUM_CH-1:0] enc_b,
    input  logic              sat_mode,
    input  logic              load_en,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [CH_W-1:0]   rd_sel,
    output logic [WIDTH-1:0]  rd_data,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int             SCW       = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam logic [SCW-1:0] STRB_LAST = SCW'(DB_DIV - 1);

    logic [SCW-1:0]   strb_cnt;
    logic             strobe;
    logic [WIDTH-1:0] pwm_cnt;
    logic [WIDTH-1:0] level [NUM_CH];
    logic [WIDTH-1:0] rd_next;

    // With DB_DIV = 1 the counter sits at 0 and strobe stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            strb_cnt <= '0;
        end else if (strb_cnt == STRB_LAST) begin
            strb_cnt <= '0;
        end else begin
            strb_cnt <= strb_cnt + 1'b1;
        end
    end

    assign strobe = (strb_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [WIDTH-1:0] OFFSET =
            (PHASE_SPREAD != 0) ? WIDTH'(phase_off(i, NUM_CH, WIDTH)) : '0;

        logic             load_hit;
        logic [WIDTH-1:0] phase;
        logic [WIDTH-1:0] shadow;
        logic [WIDTH-1:0] eff;
        logic             pwm_q;

        assign load_hit = load_en && (load_ch == CH_W'(i));

        enc_channel #(
            .WIDTH (WIDTH),
            .STEP  (STEP)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .enc_a    (enc_a[i]),
            .enc_b    (enc_b[i]),
            .strobe   (strobe),
            .sat_mode (sat_mode),
            .load     (load_hit),
            .load_val (load_val),
            .level    (level[i])
        );

        assign phase = pwm_cnt + OFFSET;
        // The live level is used only on the first cycle of the period so the
        // comparator threshold cannot move mid-period.
        assign eff   = (phase == '0) ? level[i] : shadow;

        always_ff @(posedge clk) begin
            if (reset) begin
                shadow <= '0;
                pwm_q  <= 1'b0;
            end else begin
                if (phase == '0) shadow <= level[i];
                pwm_q <= (phase < eff);
            end
        end

        assign pwm_out[i] = pwm_q;
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == CH_W'(i)) rd_next = level[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_enc_pwm_mixer.sv
// tb/tb_enc_pwm_mixer.sv - self-checking bench for enc_pwm_mixer

module tb_enc_pwm_mixer;

    localparam int OP_UP = 0;
    localparam int OP_DN = 1;
    localparam int OP_LD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] enc_a, enc_b;
    logic       sat_mode, load_en;
    logic [1:0] load_ch, rd_sel;
    logic [7:0] load_val, rd_data;
    logic [3:0] pwm_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int op;
        int ch;
        int val;
        int sat;
        int exp;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    enc_pwm_mixer dut (
        .clk      (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .sat_mode (sat_mode),
        .load_en  (load_en),
        .load_ch  (load_ch),
        .load_val (load_val),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .pwm_out  (pwm_out)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_load(input int ch, input int val);
        @(negedge clk);
        load_en  = 1'b1;
        load_ch  = 2'(ch);
        load_val = 8'(val);
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic do_step(input int ch, input logic b);
        @(negedge clk);
        enc_b[ch] = b;
        repeat (3) @(negedge clk);
        enc_a[ch] = 1'b1;
        repeat (8) @(negedge clk);
        enc_a[ch] = 1'b0;
        repeat (8) @(negedge clk);
        enc_b[ch] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic read_level(input int ch, output int v);
        @(negedge clk);
        rd_sel = 2'(ch);
        @(negedge clk);
        v = int'(rd_data);
    endtask

    initial begin
        int  got;
        int  found;
        int  hi_cnt, rise_cnt, rise_idx;
        int  rise_at [4];
        bit  samp [4][256];
        bit  s0 [512];
        bit  prev;

        reset    = 1'b1;
        enc_a    = 4'hF;
        enc_b    = 4'hF;
        sat_mode = 1'b1;
        load_en  = 1'b0;
        load_ch  = 2'd0;
        load_val = 8'd0;
        rd_sel   = 2'd0;

        // Reset with every pin high: nothing may leak out for a whole period.
        repeat (5) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            check("rst_pwm_low", int'(pwm_out), 0);
            check("rst_rd_zero", int'(rd_data), 0);
            rd_sel = 2'(k % 4);
        end
        enc_a = 4'h0;
        repeat (10) @(negedge clk);
        enc_b = 4'h0;
        repeat (10) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            read_level(c, got);
            check($sformatf("rst_level%0d", c), got, 0);
        end

        // Table: step / load operations, each followed by a readback.
        tbl.push_back('{OP_UP, 1, 0,   1, 1});
        tbl.push_back('{OP_UP, 1, 0,   1, 2});
        tbl.push_back('{OP_UP, 1, 0,   1, 3});
        tbl.push_back('{OP_DN, 1, 0,   1, 2});
        tbl.push_back('{OP_LD, 0, 254, 1, 254});
        tbl.push_back('{OP_UP, 0, 0,   1, 255});
        tbl.push_back('{OP_UP, 0, 0,   1, 255});
        tbl.push_back('{OP_UP, 0, 0,   1, 255});
        tbl.push_back('{OP_LD, 0, 1,   1, 1});
        tbl.push_back('{OP_DN, 0, 0,   1, 0});
        tbl.push_back('{OP_DN, 0, 0,   1, 0});
        tbl.push_back('{OP_LD, 3, 255, 0, 255});
        tbl.push_back('{OP_UP, 3, 0,   0, 0});
        tbl.push_back('{OP_DN, 3, 0,   0, 255});

        for (int i = 0; i < tbl.size(); i++) begin
            sat_mode = tbl[i].sat[0];
            case (tbl[i].op)
                OP_UP:   do_step(tbl[i].ch, 1'b0);
                OP_DN:   do_step(tbl[i].ch, 1'b1);
                default: do_load(tbl[i].ch, tbl[i].val);
            endcase
            read_level(tbl[i].ch, got);
            check($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // Single-cycle bounce on A must not step.
        @(negedge clk);
        enc_a[3] = 1'b1;
        @(negedge clk);
        enc_a[3] = 1'b0;
        repeat (10) @(negedge clk);
        read_level(3, got);
        check("bounce_no_step", got, 255);

        // Latency: level[1] = 2 changes on the 5th edge, visible on rd_data one edge later.
        @(negedge clk);
        rd_sel = 2'd1;
        repeat (2) @(negedge clk);
        enc_a[1] = 1'b1;
        repeat (5) @(negedge clk);
        check("lat_edge5_old", int'(rd_data), 2);
        @(negedge clk);
        check("lat_edge6_new", int'(rd_data), 3);
        enc_a[1] = 1'b0;
        repeat (10) @(negedge clk);

        // Load on ch2 collides with a step on ch2; ch0 steps in the same cycle.
        sat_mode = 1'b0;
        do_load(0, 10);
        do_load(2, 20);
        @(negedge clk);
        enc_a[0] = 1'b1;
        enc_a[2] = 1'b1;
        repeat (4) @(negedge clk);
        load_en  = 1'b1;
        load_ch  = 2'd2;
        load_val = 8'h40;
        @(negedge clk);
        load_en  = 1'b0;
        enc_a[0] = 1'b0;
        enc_a[2] = 1'b0;
        repeat (10) @(negedge clk);
        read_level(2, got);
        check("load_prio_ch2", got, 64);
        read_level(0, got);
        check("load_prio_ch0", got, 11);

        // All channels at 64: 64 high cycles each, rises staggered by 64.
        for (int c = 0; c < 4; c++) do_load(c, 64);
        repeat (520) @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) samp[c][k] = pwm_out[c];
        end
        for (int c = 0; c < 4; c++) begin
            hi_cnt   = 0;
            rise_cnt = 0;
            rise_idx = 0;
            for (int k = 0; k < 256; k++) begin
                if (samp[c][k]) hi_cnt++;
                if (samp[c][k] && !samp[c][(k + 255) % 256]) begin
                    rise_cnt++;
                    rise_idx = k;
                end
            end
            rise_at[c] = rise_idx;
            check($sformatf("pwm64_high_ch%0d", c), hi_cnt, 64);
            check($sformatf("pwm64_rises_ch%0d", c), rise_cnt, 1);
        end
        for (int c = 1; c < 4; c++)
            check($sformatf("pwm64_offset_ch%0d", c),
                  (rise_at[c] - rise_at[0] + 256) % 256, (256 - 64 * c) % 256);

        // Mid-period load of 200 on ch0: old duty holds until the next boundary.
        found = 0;
        prev  = pwm_out[0];
        for (int k = 0; k < 600 && found == 0; k++) begin
            @(negedge clk);
            if (pwm_out[0] && !prev) found = 1;
            prev = pwm_out[0];
        end
        check("glitch_sync_found", found, 1);
        if (found != 0) begin
            s0[0] = 1'b1;
            for (int k = 1; k < 512; k++) begin
                @(negedge clk);
                s0[k] = pwm_out[0];
                if (k == 99) begin
                    load_en  = 1'b1;
                    load_ch  = 2'd0;
                    load_val = 8'd200;
                end
                if (k == 100) load_en = 1'b0;
            end
            hi_cnt   = 0;
            rise_cnt = 0;
            for (int k = 0; k < 256; k++) if (s0[k]) hi_cnt++;
            check("glitch_old_duty", hi_cnt, 64);
            hi_cnt = 0;
            for (int k = 256; k < 512; k++) if (s0[k]) hi_cnt++;
            check("glitch_new_duty", hi_cnt, 200);
            for (int k = 1; k < 512; k++) if (s0[k] && !s0[k-1]) rise_cnt++;
            check("glitch_rise_count", rise_cnt, 1);
            check("glitch_rise_at_256", int'(s0[256]), 1);
            check("glitch_high_455", int'(s0[455]), 1);
            check("glitch_low_456", int'(s0[456]), 0);
        end

        // Reset mid-period forces outputs low at once.
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            if (pwm_out != 4'h0) found = 1;
        end
        check("abort_pwm_seen_high", found, 1);
        rd_sel = 2'd0;
        reset  = 1'b1;
        @(negedge clk);
        check("abort_pwm_low", int'(pwm_out), 0);
        check("abort_rd_zero", int'(rd_data), 0);
        reset = 1'b0;
        read_level(0, got);
        check("abort_level_cleared", got, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
